pc_sequencer: RTL

- Parametrised successor to the combinational next-PC logic.
- Owns the fetch PC register and computes branch, jump and jump-register targets from decode-stage inputs.
- Tolerates a slow instruction memory by holding a pending redirect, and produces the IF flush and link value.
- Sits between the hazard unit/decode stage and instruction fetch.

---
 rtl/pc_seq_pkg.sv | 26 ++
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer_npc_target.sv | 37 +++
 rtl/pc_sequencer.sv | 91 +++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the fetch PC sequencer.
//   seq_state_e : sequencer state (RUN, PEND)
//   cf_kind_e   : control-flow kind driving the target mux
//   cf_kind()   : collapses the one-hot decode into a kind
package pc_seq_pkg;
    typedef enum logic {RUN = 1'b0, PEND = 1'b1} seq_state_e;

    typedef enum logic [1:0] {
        CF_NONE   = 2'd0,
        CF_BRANCH = 2'd1,
        CF_JUMP   = 2'd2,
        CF_JR     = 2'd3
    } cf_kind_e;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;
    localparam int          DEF_IMM_SHIFT = 2;

    function automatic cf_kind_e cf_kind(input logic beq, input logic bne,
                                         input logic j, input logic jal,
                                         input logic jr);
        if (jr)             return CF_JR;
        else if (j || jal)  return CF_JUMP;
        else if (beq || bne) return CF_BRANCH;
        else                return CF_NONE;
    endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode/hazard side <-> fetch PC sequencer bundle.
//   master : decode/hazard side (drives stall, if_ready, decode fields)
//   slave  : the sequencer (drives pc, pc_plus4, pc_src, flush, link, addr_err)
interface pc_sequencer_if #(parameter int XLEN = 32);
    logic            stall;
    logic            if_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_pc_plus4;
    logic [25:0]     imm26;
    logic            zero;
    logic            beq, bne, j, jal, jr;
    logic [XLEN-1:0] jr_target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            pc_src;
    logic            flush;
    logic [XLEN-1:0] link;
    logic            addr_err;

    modport master (
        output stall, if_ready, id_valid, id_pc_plus4, imm26, zero,
               beq, bne, j, jal, jr, jr_target,
        input  pc, pc_plus4, pc_src, flush, link, addr_err
    );

    modport slave (
        input  stall, if_ready, id_valid, id_pc_plus4, imm26, zero,
               beq, bne, j, jal, jr, jr_target,
        output pc, pc_plus4, pc_src, flush, link, addr_err
    );
endinterface

// File: rtl/pc_sequencer_npc_target.sv
// npc_target: combinational redirect target mux.
//   kind_i        : control-flow kind
//   id_pc_plus4_i : PC+PC_INC of the ID instruction
//   imm26_i       : immediate / jump index
//   jr_target_i   : register value for jr
//   target_o      : computed target (low IMM_SHIFT bits always zero)
//   misalign_o    : jr_target had nonzero low bits
module npc_target
    import pc_seq_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int IMM_SHIFT = DEF_IMM_SHIFT
) (
    input  cf_kind_e        kind_i,
    input  logic [XLEN-1:0] id_pc_plus4_i,
    input  logic [25:0]     imm26_i,
    input  logic [XLEN-1:0] jr_target_i,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);
    logic [XLEN-1:0] br_off;

    // Branch offset: sign-extend the 16-bit field, then scale to bytes.
    assign br_off     = {{(XLEN-16){imm26_i[15]}}, imm26_i[15:0]} << IMM_SHIFT;
    assign misalign_o = |jr_target_i[IMM_SHIFT-1:0];

    always_comb begin
        target_o = '0;
        case (kind_i)
            CF_BRANCH: target_o = id_pc_plus4_i + br_off;
            CF_JUMP:   target_o = {id_pc_plus4_i[XLEN-1:26+IMM_SHIFT], imm26_i,
                                   {IMM_SHIFT{1'b0}}};
            CF_JR:     target_o = {jr_target_i[XLEN-1:IMM_SHIFT], {IMM_SHIFT{1'b0}}};
            default:   target_o = '0;
        endcase
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register and redirect sequencing.
//   clk, rst_n : clock, async active-low reset
//   bus        : pc_sequencer_if.slave (decode inputs, pc/flush/link outputs)
// A redirect seen while instruction memory is not ready is parked in
// pend_target until the first if_ready, so the slow fetch completes first.
// Build option: PC_SEQ_DELAY_SLOT_EN -- MIPS delay slot (no flush,
// link = id_pc_plus4 + PC_INC).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEF_RESET_PC),
    parameter int              IMM_SHIFT = DEF_IMM_SHIFT,
    parameter int              PC_INC    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);
    seq_state_e      state_q;
    logic [XLEN-1:0] pc_q, pend_target_q;
    logic            addr_err_q;

    cf_kind_e        kind;
    logic [XLEN-1:0] target;
    logic            misalign, cond, take, advance;

    assign kind    = cf_kind(bus.beq, bus.bne, bus.j, bus.jal, bus.jr);
    assign cond    = (bus.beq & bus.zero) | (bus.bne & ~bus.zero) |
                     bus.j | bus.jal | bus.jr;
    // rst_n gating keeps pc_src/flush quiet while reset is asserted.
    assign take    = rst_n & bus.id_valid & ~bus.stall & cond;
    assign advance = ~bus.stall & bus.if_ready;

    npc_target #(.XLEN(XLEN), .IMM_SHIFT(IMM_SHIFT)) u_tgt (
        .kind_i        (kind),
        .id_pc_plus4_i (bus.id_pc_plus4),
        .imm26_i       (bus.imm26),
        .jr_target_i   (bus.jr_target),
        .target_o      (target),
        .misalign_o    (misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            addr_err_q    <= 1'b0;
        end else begin
            addr_err_q <= take & bus.jr & misalign;
            case (state_q)
                RUN: begin
                    if (take && bus.if_ready) begin
                        pc_q <= target;
                    end else if (take) begin
                        pend_target_q <= target;
                        state_q       <= PEND;
                    end else if (advance) begin
                        pc_q <= pc_q + XLEN'(PC_INC);
                    end
                end
                PEND: begin
                    // ID holds a bubble here; a stray take is ignored and the
                    // parked target wins. Stall cannot block the load.
                    if (bus.if_ready) begin
                        pc_q    <= pend_target_q;
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_q + XLEN'(PC_INC);
    assign bus.pc_src   = take;
    assign bus.addr_err = addr_err_q;

`ifdef PC_SEQ_DELAY_SLOT_EN
    // The word in IF is the delay slot and executes, so nothing is killed.
    assign bus.flush = 1'b0;
    assign bus.link  = bus.id_pc_plus4 + XLEN'(PC_INC);
`else
    // One wrong-path fetch dies when the redirect actually lands on pc.
    assign bus.flush = rst_n & ((state_q == RUN) ? (take & bus.if_ready)
                                                 : bus.if_ready);
    assign bus.link  = bus.id_pc_plus4;
`endif
endmodule
